// File: rtl/jbi_min_issue_pkg.sv
// Shared types, default geometry and field-width helpers for the JBI RHQ
// issue sequencer.
package jbi_min_issue_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  localparam int unsigned DEF_NUM_BANKS  = 32'd4;
  localparam int unsigned DEF_CREDITS    = 32'd2;
  localparam int unsigned DEF_DATA_BEATS = 32'd8;

  // Index width for n items, never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 32'd1) ? $clog2(n) : 32'd1;
  endfunction

  function automatic int unsigned bank_w(input int unsigned num_banks);
    return idx_w(num_banks);
  endfunction

  function automatic int unsigned beat_w(input int unsigned data_beats);
    return idx_w(data_beats);
  endfunction

  // A counter must hold 0..credits inclusive.
  function automatic int unsigned credit_w(input int unsigned credits);
    return idx_w(credits + 32'd1);
  endfunction

endpackage

// File: rtl/jbi_min_issue_credit.sv
// One per-bank outstanding-request credit counter: saturating up/down with a
// one-cycle error pulse when a return arrives on a full counter.
module jbi_min_issue_credit
  import jbi_min_issue_pkg::*;
#(
  parameter int unsigned CREDITS = DEF_CREDITS,
  localparam int unsigned CW = credit_w(CREDITS)
) (
  input  logic clk,
  input  logic rst,
  input  logic dec,
  input  logic ret,
  output logic avail,
  output logic err
);

  localparam logic [CW-1:0] CNT_MAX = CW'(CREDITS);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          err_d;

  // Next count: a decision and a return in the same cycle cancel out.
  always_comb begin
    cnt_d = cnt_q;
    err_d = 1'b0;
    case ({dec, ret})
      2'b10: begin
        if (cnt_q != {CW{1'b0}}) begin
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          cnt_d = cnt_q;
        end
      end
      2'b01: begin
        if (cnt_q == CNT_MAX) begin
          cnt_d = cnt_q;
          err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: cnt_d = cnt_q;
    endcase
  end

  // Counter register, reloaded to full credit on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= CNT_MAX;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign avail = (cnt_q != {CW{1'b0}});
  assign err   = err_d;

endmodule

// File: rtl/jbi_min_rq_issue_sched.sv
// In-order RHQ issue sequencer: gates the head header on enable and bank
// credit, pops it, then streams write data beats out of the WDQ.
module jbi_min_rq_issue_sched
  import jbi_min_issue_pkg::*;
#(
  parameter int unsigned NUM_BANKS  = DEF_NUM_BANKS,
  parameter int unsigned CREDITS    = DEF_CREDITS,
  parameter int unsigned DATA_BEATS = DEF_DATA_BEATS,
  localparam int unsigned BW = bank_w(NUM_BANKS),
  localparam int unsigned TW = beat_w(DATA_BEATS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 csr_issue_en,
  input  logic                 rhq_drdy,
  input  logic                 rhq_rdata_rw,
  input  logic [BW-1:0]        rhq_rdata_bank,
  input  logic [NUM_BANKS-1:0] sct_credit_ret,
  output logic                 issue_rhq_pop,
  output logic                 sct_hdr_vld,
  output logic                 sct_data_vld,
  output logic [BW-1:0]        sct_bank,
  output logic [TW-1:0]        sct_beat,
  output logic                 issue_stall,
  output logic                 credit_err
);

  localparam int unsigned   NB_PAD    = 32'd1 << BW;
  localparam logic [TW-1:0] LAST_BEAT = TW'(DATA_BEATS - 32'd1);
  localparam logic [TW-1:0] BEAT_ONE  = TW'(1);

  state_e                state_q, state_d;
  logic [BW-1:0]         txn_bank_q, txn_bank_d;
  logic                  txn_rd_q, txn_rd_d;
  logic [TW-1:0]         beat_cnt_q, beat_cnt_d;
  logic                  pop_q, pop_d;
  logic                  hdr_q, hdr_d;
  logic                  data_q, data_d;
  logic [BW-1:0]         bank_q, bank_d;
  logic [TW-1:0]         beat_q, beat_d;
  logic                  credit_err_q, credit_err_d;

  logic [NUM_BANKS-1:0]  dec_vec_s;
  logic [NUM_BANKS-1:0]  avail_s;
  logic [NUM_BANKS-1:0]  err_s;
  logic [NB_PAD-1:0]     avail_pad_s;
  logic                  head_avail_s;
  logic                  idle_req_s;
  logic                  decide_s;

  genvar g;
  generate
    for (g = 0; g < NUM_BANKS; g++) begin : g_credit
      assign dec_vec_s[g] = decide_s & (rhq_rdata_bank == BW'(g));
      jbi_min_issue_credit #(.CREDITS(CREDITS)) u_credit (
        .clk   (clk),
        .rst   (rst),
        .dec   (dec_vec_s[g]),
        .ret   (sct_credit_ret[g]),
        .avail (avail_s[g]),
        .err   (err_s[g])
      );
    end
  endgenerate

  // Bank codes beyond NUM_BANKS map to "no credit" so they can never issue.
  always_comb begin
    avail_pad_s                = {NB_PAD{1'b0}};
    avail_pad_s[NUM_BANKS-1:0] = avail_s;
  end

  assign head_avail_s = avail_pad_s[rhq_rdata_bank];
  assign idle_req_s   = (state_q == ST_IDLE) & csr_issue_en & rhq_drdy;
  assign decide_s     = idle_req_s & head_avail_s;
  assign issue_stall  = idle_req_s & ~head_avail_s;

  // Sequencer next state plus the output values that state will present.
  always_comb begin
    state_d    = state_q;
    txn_bank_d = txn_bank_q;
    txn_rd_d   = txn_rd_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (decide_s) begin
          state_d    = ST_HDR;
          txn_bank_d = rhq_rdata_bank;
          txn_rd_d   = rhq_rdata_rw;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HDR: begin
        beat_cnt_d = {TW{1'b0}};
        if (txn_rd_q) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (beat_cnt_q == LAST_BEAT) begin
          state_d    = ST_IDLE;
          beat_cnt_d = {TW{1'b0}};
        end else begin
          state_d    = ST_DATA;
          beat_cnt_d = beat_cnt_q + BEAT_ONE;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        beat_cnt_d = {TW{1'b0}};
      end
    endcase

    pop_d  = (state_d == ST_HDR);
    hdr_d  = (state_d == ST_HDR);
    data_d = (state_d == ST_DATA);
    if (state_d != ST_IDLE) begin
      bank_d = txn_bank_d;
    end else begin
      bank_d = {BW{1'b0}};
    end
    if (data_d) begin
      beat_d = beat_cnt_d;
    end else begin
      beat_d = {TW{1'b0}};
    end
    credit_err_d = credit_err_q | (|err_s);
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      txn_bank_q   <= {BW{1'b0}};
      txn_rd_q     <= 1'b0;
      beat_cnt_q   <= {TW{1'b0}};
      pop_q        <= 1'b0;
      hdr_q        <= 1'b0;
      data_q       <= 1'b0;
      bank_q       <= {BW{1'b0}};
      beat_q       <= {TW{1'b0}};
      credit_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      txn_bank_q   <= txn_bank_d;
      txn_rd_q     <= txn_rd_d;
      beat_cnt_q   <= beat_cnt_d;
      pop_q        <= pop_d;
      hdr_q        <= hdr_d;
      data_q       <= data_d;
      bank_q       <= bank_d;
      beat_q       <= beat_d;
      credit_err_q <= credit_err_d;
    end
  end

  assign issue_rhq_pop = pop_q;
  assign sct_hdr_vld   = hdr_q;
  assign sct_data_vld  = data_q;
  assign sct_bank      = bank_q;
  assign sct_beat      = beat_q;
  assign credit_err    = credit_err_q;

endmodule

// File: tb/tb_jbi_min_rq_issue_sched.sv
// Directed bench for the RHQ issue sequencer with hand-computed expectations.
module tb_jbi_min_rq_issue_sched;

  logic       clk;
  logic       rst;
  logic       csr_issue_en;
  logic       rhq_drdy;
  logic       rhq_rdata_rw;
  logic [1:0] rhq_rdata_bank;
  logic [3:0] sct_credit_ret;
  logic       issue_rhq_pop;
  logic       sct_hdr_vld;
  logic       sct_data_vld;
  logic [1:0] sct_bank;
  logic [2:0] sct_beat;
  logic       issue_stall;
  logic       credit_err;

  int n_cmp;
  int n_bad;

  jbi_min_rq_issue_sched dut (
    .clk            (clk),
    .rst            (rst),
    .csr_issue_en   (csr_issue_en),
    .rhq_drdy       (rhq_drdy),
    .rhq_rdata_rw   (rhq_rdata_rw),
    .rhq_rdata_bank (rhq_rdata_bank),
    .sct_credit_ret (sct_credit_ret),
    .issue_rhq_pop  (issue_rhq_pop),
    .sct_hdr_vld    (sct_hdr_vld),
    .sct_data_vld   (sct_data_vld),
    .sct_bank       (sct_bank),
    .sct_beat       (sct_beat),
    .issue_stall    (issue_stall),
    .credit_err     (credit_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input int pop, input int hdr,
                          input int dv, input int bank, input int beat);
    chk({tag, ".pop"},  32'(issue_rhq_pop), 32'(pop));
    chk({tag, ".hdr"},  32'(sct_hdr_vld),   32'(hdr));
    chk({tag, ".data"}, 32'(sct_data_vld),  32'(dv));
    chk({tag, ".bank"}, 32'(sct_bank),      32'(bank));
    chk({tag, ".beat"}, 32'(sct_beat),      32'(beat));
  endtask

  // Advance one clock; inputs change and outputs are sampled at the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_head(input logic drdy, input logic rw, input logic [1:0] bank);
    rhq_drdy       = drdy;
    rhq_rdata_rw   = rw;
    rhq_rdata_bank = bank;
  endtask

  task automatic return_credits(input logic [3:0] mask);
    sct_credit_ret = mask;
    step();
    sct_credit_ret = 4'b0000;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    csr_issue_en = 1'b0;
    sct_credit_ret = 4'b0000;
    set_head(1'b0, 1'b1, 2'd0);
    step();
    step();
    rst = 1'b0;
    chk_outs("reset", 0, 0, 0, 0, 0);
    chk("reset.stall", 32'(issue_stall), 32'd0);
    chk("reset.err", 32'(credit_err), 32'd0);

    // Back-to-back reads to banks 0,1,2: one header every two cycles.
    csr_issue_en = 1'b1;
    for (int b = 0; b < 3; b++) begin
      set_head(1'b1, 1'b1, 2'(b));
      step();
      chk_outs($sformatf("rd%0d.hdr", b), 1, 1, 0, b, 0);
      if (b == 2) set_head(1'b0, 1'b1, 2'd0);
      step();
      chk_outs($sformatf("rd%0d.idle", b), 0, 0, 0, 0, 0);
    end
    // Each bank sits at 1 now, so one return apiece must not overflow.
    return_credits(4'b0111);
    step();
    chk("rd.ret_no_err", 32'(credit_err), 32'd0);

    // Single write to bank 3, then a read that issues at the earliest slot.
    set_head(1'b1, 1'b0, 2'd3);
    step();
    chk_outs("wr.hdr", 1, 1, 0, 3, 0);
    set_head(1'b0, 1'b1, 2'd0);
    for (int b = 0; b < 8; b++) begin
      step();
      chk_outs($sformatf("wr.beat%0d", b), 0, 0, 1, 3, b);
    end
    set_head(1'b1, 1'b1, 2'd0);
    step();
    chk_outs("wr.after", 0, 0, 0, 0, 0);
    step();
    chk_outs("wr.next_rd", 1, 1, 0, 0, 0);
    set_head(1'b0, 1'b1, 2'd0);
    step();
    return_credits(4'b1001);
    step();
    chk("wr.ret_no_err", 32'(credit_err), 32'd0);

    // Credit exhaustion on bank 2.
    set_head(1'b1, 1'b1, 2'd2);
    step();
    chk_outs("ex.hdr1", 1, 1, 0, 2, 0);
    step();
    chk("ex.stall_c1", 32'(issue_stall), 32'd0);
    step();
    chk_outs("ex.hdr2", 1, 1, 0, 2, 0);
    step();
    chk("ex.stall_c0a", 32'(issue_stall), 32'd1);
    step();
    chk("ex.stall_c0b", 32'(issue_stall), 32'd1);
    chk_outs("ex.blocked", 0, 0, 0, 0, 0);
    sct_credit_ret = 4'b0100;
    step();
    sct_credit_ret = 4'b0000;
    chk("ex.ret_pop", 32'(issue_rhq_pop), 32'd0);
    chk("ex.stall_clr", 32'(issue_stall), 32'd0);
    step();
    chk_outs("ex.hdr3", 1, 1, 0, 2, 0);
    set_head(1'b0, 1'b1, 2'd0);
    step();
    return_credits(4'b0100);
    return_credits(4'b0100);
    step();
    chk("ex.ret_no_err", 32'(credit_err), 32'd0);

    // Decision and return on bank 1 in the same cycle leave the count at 1.
    set_head(1'b1, 1'b1, 2'd1);
    step();
    chk_outs("sim.hdr1", 1, 1, 0, 1, 0);
    step();
    sct_credit_ret = 4'b0010;
    step();
    sct_credit_ret = 4'b0000;
    chk_outs("sim.hdr2", 1, 1, 0, 1, 0);
    step();
    step();
    chk_outs("sim.hdr3", 1, 1, 0, 1, 0);
    step();
    chk("sim.stall_c0", 32'(issue_stall), 32'd1);
    set_head(1'b0, 1'b1, 2'd0);
    return_credits(4'b0010);
    return_credits(4'b0010);
    step();
    chk("sim.no_err", 32'(credit_err), 32'd0);
    // Bank 0 is full: a return saturates and sets the sticky error.
    return_credits(4'b0001);
    chk("sat.err", 32'(credit_err), 32'd1);
    step();
    step();
    chk("sat.err_sticky", 32'(credit_err), 32'd1);

    // Enable drops during write beat 3: the write finishes, nothing new issues.
    set_head(1'b1, 1'b0, 2'd3);
    step();
    chk_outs("en.hdr", 1, 1, 0, 3, 0);
    set_head(1'b1, 1'b1, 2'd0);
    for (int b = 0; b < 8; b++) begin
      step();
      chk_outs($sformatf("en.beat%0d", b), 0, 0, 1, 3, b);
      if (b == 3) csr_issue_en = 1'b0;
    end
    step();
    chk_outs("en.idle1", 0, 0, 0, 0, 0);
    step();
    chk_outs("en.idle2", 0, 0, 0, 0, 0);
    chk("en.stall", 32'(issue_stall), 32'd0);

    // Reset at write beat 5 clears everything and reloads the credits.
    csr_issue_en = 1'b1;
    set_head(1'b1, 1'b0, 2'd3);
    step();
    chk_outs("rs.hdr", 1, 1, 0, 3, 0);
    set_head(1'b0, 1'b1, 2'd0);
    for (int b = 0; b < 6; b++) step();
    chk_outs("rs.beat5", 0, 0, 1, 3, 5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_outs("rs.out", 0, 0, 0, 0, 0);
    chk("rs.err", 32'(credit_err), 32'd0);
    chk("rs.stall", 32'(issue_stall), 32'd0);
    set_head(1'b1, 1'b1, 2'd3);
    step();
    chk_outs("rs.rd1", 1, 1, 0, 3, 0);
    step();
    chk("rs.stall_c1", 32'(issue_stall), 32'd0);
    step();
    chk_outs("rs.rd2", 1, 1, 0, 3, 0);
    step();
    chk("rs.stall_c0", 32'(issue_stall), 32'd1);
    set_head(1'b0, 1'b1, 2'd0);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
